// File: rtl/memory_arbiter_if.sv
// Bus bundle for memory_arbiter: data-side requester, two ifetch requesters
// and the single shared memory port.
interface memory_arbiter_if;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CORES  = 2;

    logic                          dREN;
    logic                          dWEN;
    logic [WORD_W-1:0]             daddr;
    logic [WORD_W-1:0]             dstore;
    logic                          dwait;
    logic [WORD_W-1:0]             dload;

    logic [CORES-1:0]              iREN;
    logic [CORES-1:0][WORD_W-1:0]  iaddr;
    logic [CORES-1:0]              iwait;
    logic [CORES-1:0][WORD_W-1:0]  iload;

    logic                          ramREN;
    logic                          ramWEN;
    logic [WORD_W-1:0]             ramaddr;
    logic [WORD_W-1:0]             ramstore;
    logic                          ramwait;
    logic [WORD_W-1:0]             ramload;

    // Arbiter side.
    modport slave (
        input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramwait, ramload,
        output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Requester / memory side.
    modport master (
        output dREN, dWEN, daddr, dstore, iREN, iaddr, ramwait, ramload,
        input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one memory port between the data side and two ifetch requesters.
// Optional starvation guard for ifetch enabled by macro ARB_STARVE_GUARD_EN.
module memory_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic             CLK,
    input  logic             RST,
    memory_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DGNT, I0GNT, I1GNT} state_t;

    state_t state;
    logic   last;
    logic   d_req;
    logic   i_pick;
    logic   active;
    logic   done;
    logic   starve_hit;

    if (STARVE_LIMIT > 15) begin : g_limit_check
        $error("STARVE_LIMIT must fit the 4-bit starvation counter");
    end

    assign d_req  = bus.dREN | bus.dWEN;
    // Both cores asking: the one not served last wins.
    assign i_pick = (bus.iREN == 2'b11) ? ~last : bus.iREN[1];

    // Granted requester still holding its request.
    always_comb begin
        active = 1'b0;
        case (state)
            DGNT:    active = d_req;
            I0GNT:   active = bus.iREN[0];
            I1GNT:   active = bus.iREN[1];
            default: active = 1'b0;
        endcase
    end

    assign done = active & ~bus.ramwait;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    // Data completions while ifetch waits; cleared when ifetch is served.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve_cnt <= '0;
        end else if (done) begin
            if (state == DGNT) begin
                if ((|bus.iREN) && (starve_cnt != 4'hF)) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    assign starve_hit = (starve_cnt >= 4'(STARVE_LIMIT)) && (|bus.iREN);
`else
    assign starve_hit = 1'b0;
`endif

    // Grant state machine; a grant ends on completion or withdrawal.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && !starve_hit) begin
                        state <= DGNT;
                    end else if (|bus.iREN) begin
                        state <= i_pick ? I1GNT : I0GNT;
                    end
                end
                default: begin
                    if (!active || !bus.ramwait) begin
                        state <= IDLE;
                        if (active && (state != DGNT)) begin
                            last <= (state == I1GNT);
                        end
                    end
                end
            endcase
        end
    end

    // Memory port and wait/load decode, gated by the live request.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        bus.iwait    = 2'b11;
        bus.iload    = '0;
        case (state)
            DGNT: begin
                if (d_req) begin
                    bus.ramWEN  = bus.dWEN;
                    bus.ramREN  = ~bus.dWEN;
                    bus.ramaddr = bus.daddr;
                    if (bus.dWEN) begin
                        bus.ramstore = bus.dstore;
                    end
                    if (!bus.ramwait) begin
                        bus.dwait = 1'b0;
                        bus.dload = bus.ramload;
                    end
                end
            end
            I0GNT: begin
                if (bus.iREN[0]) begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr[0];
                    if (!bus.ramwait) begin
                        bus.iwait[0] = 1'b0;
                        bus.iload[0] = bus.ramload;
                    end
                end
            end
            I1GNT: begin
                if (bus.iREN[1]) begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr[1];
                    if (!bus.ramwait) begin
                        bus.iwait[1] = 1'b0;
                        bus.iload[1] = bus.ramload;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 SHALL have port CLK, input, 1 bit: system clock, rising-edge active.
REQ-003 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have inputs dREN, dWEN (1 bit each) and daddr, dstore (32 bits each): data-side request from the coherence controller.
REQ-005 SHALL have input iREN, 2 bits: instruction fetch request, one bit per core (bit n = core n).
REQ-006 SHALL have input iaddr, 2x32 bits: per-core fetch address.
REQ-007 SHALL have outputs dwait (1 bit) and dload (32 bits): data-side stall and read data.
REQ-008 SHALL have outputs iwait (2 bits) and iload (2x32 bits): per-core fetch stall and instruction word.
REQ-009 SHALL have outputs ramREN, ramWEN (1 bit each) and ramaddr, ramstore (32 bits each): single shared memory port.
REQ-010 SHALL have inputs ramwait (1 bit: access not yet complete) and ramload (32 bits: read data).
REQ-011 SHALL have parameter STARVE_LIMIT, default 8: maximum consecutive data grants while an ifetch is pending.

Function
REQ-012 SHALL implement states IDLE, DGNT, I0GNT, I1GNT.
REQ-013 In IDLE, SHALL select DGNT if dREN|dWEN, else the round-robin icache winner, else stay IDLE.
REQ-014 Icache round-robin: 1-bit last-served pointer; when both iREN bits are set, the core not last served wins; pointer updates on each icache completion.
REQ-015 In xGNT, SHALL drive only the granted requester's address, data and strobe to the ram port; all other ram outputs SHALL be 0.
REQ-016 dWEN with dREN both set SHALL be treated as a write: ramWEN=1, ramREN=0.
REQ-017 In xGNT with ramwait=0, SHALL drop the granted requester's wait for exactly one cycle, pass ramload to its load bus and return to IDLE; latency = 1 arbitration cycle + memory latency.
REQ-018 All non-granted waits SHALL stay 1; all loads SHALL be 0 when their wait is 1.
REQ-019 If the granted requester deasserts its request before completion, the ram strobes SHALL drop in that same cycle (combinationally gated) and the state SHALL return to IDLE with no wait pulse.
REQ-020 Grants SHALL NOT be pre-empted; a new data request during IxGNT waits for IDLE.
REQ-021 A request arriving in the completion cycle SHALL be arbitrated in the following IDLE cycle.

Reset
REQ-022 RST SHALL force IDLE asynchronously, including mid-access; the pointer selects core 0 first; the starvation counter clears.
REQ-023 While RST is asserted, ramREN=ramWEN=0, ramaddr=ramstore=0, dwait=1, iwait=2'b11, and all load buses are 0.
REQ-024 A memory access interrupted by reset SHALL NOT be resumed.

Configuration
REQ-025 With macro ARB_STARVE_GUARD_EN defined, a 4-bit counter SHALL increment on each data completion while any iREN is high and clear on each icache completion.
REQ-026 With ARB_STARVE_GUARD_EN defined and the counter at STARVE_LIMIT, IDLE SHALL grant the icache winner over a pending data request.
REQ-027 Without ARB_STARVE_GUARD_EN, no counter SHALL exist and the data side SHALL have strict priority.

Verification
REQ-028 Single fetch: iREN=2'b01, iaddr[0]=0x40, ramwait low after 2 cycles, ramload=0xDEADBEEF -> ramREN=1 with ramaddr=0x40; iwait[0] low for 1 cycle with iload[0]=0xDEADBEEF.
REQ-029 Contention: dREN=1 and iREN=2'b11 together -> data served first, then core 0, then core 1.
REQ-030 Write priority: dREN=dWEN=1, daddr=0x80, dstore=0x1234 -> ramWEN=1, ramREN=0, ramstore=0x1234.
REQ-031 Abort: withdraw iREN[1] mid-I1GNT -> ramREN drops the same cycle; iwait[1] never pulses; next state IDLE.
REQ-032 Reset: assert RST during DGNT -> outputs reach reset values before the next CLK edge.
REQ-033 With ARB_STARVE_GUARD_EN: dREN held high and iREN=2'b01 -> core 0 granted after the 8th data completion; without the macro -> core 0 is never granted.
